// File: rtl/spi_led_pkg.sv
// Shared types and framing constants for the SPI LED frame path.
package spi_led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_STOP = 3'd4
  } state_t;

  localparam logic [7:0] SOF0 = 8'h55;
  localparam logic [7:0] SOF1 = 8'h5B;
  localparam logic [7:0] EOF  = 8'hAA;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts while enabled, clears on demand and flags the
// terminal count TIMEOUT_CYCLES-1.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != TERM) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == TERM);

endmodule

// File: rtl/spi_frame_parser.sv
// Frame parser: SOF 55 5B, LEDS*3 payload bytes, stop byte AA, then swap and a
// delayed start pulse. Optional XOR checksum byte enabled by SPI_FRAME_CHECKSUM_EN.
module spi_frame_parser
  import spi_led_pkg::*;
#(
  parameter int LEDS           = 30,
  parameter int ADDR_WIDTH     = $clog2(LEDS * 3),
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int START_DELAY    = 2
) (
  input  logic                  i_clk50m,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_data_valid,
  input  logic                  i_cs,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_swap,
  output logic                  o_start,
  output logic                  o_frame_err,
  output logic [7:0]            o_err_count,
  output logic [2:0]            o_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LEDS * 3 - 1);
  localparam int DLY_W = $clog2(START_DELAY + 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n;
  logic                  err_n, swap_n, wr_n;
  logic                  cs_meta, cs_sync, cs_sync_d;
  logic                  cs_rise, abort;
  logic                  tmo_clr, tmo_en, tmo_tc;
  logic [DLY_W-1:0]      dly_cnt;
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]            csum, csum_n;
`endif

  // Chip select idles high, so the synchroniser resets high to avoid a false edge.
  always_ff @(posedge i_clk50m) begin
    if (!i_rst_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_sync_d <= 1'b1;
    end else begin
      cs_meta   <= i_cs;
      cs_sync   <= cs_meta;
      cs_sync_d <= cs_sync;
    end
  end

  assign cs_rise = cs_sync & ~cs_sync_d;
  assign abort   = cs_rise && (state inside {ST_DATA, ST_CSUM, ST_STOP});
  assign tmo_clr = i_data_valid || (state == ST_IDLE);
  assign tmo_en  = (state != ST_IDLE);

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (i_clk50m),
    .rst_n(i_rst_n),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .tc   (tmo_tc)
  );

  // Priority: abort drops any coincident byte; a received byte beats the timeout.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    err_n   = 1'b0;
    swap_n  = 1'b0;
    wr_n    = 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
    csum_n  = csum;
`endif
    if (abort) begin
      state_n = ST_IDLE;
      err_n   = 1'b1;
    end else if (i_data_valid) begin
      case (state)
        ST_IDLE: if (i_rx_data == SOF0) state_n = ST_SYNC;
        ST_SYNC: begin
          if (i_rx_data == SOF1) begin
            state_n = ST_DATA;
            idx_n   = '0;
`ifdef SPI_FRAME_CHECKSUM_EN
            csum_n  = '0;
`endif
          end else if (i_rx_data != SOF0) begin
            state_n = ST_IDLE;
          end
        end
        ST_DATA: begin
          wr_n = 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
          csum_n = csum ^ i_rx_data;
          if (idx == LAST_IDX) state_n = ST_CSUM;
`else
          if (idx == LAST_IDX) state_n = ST_STOP;
`endif
          else idx_n = idx + 1'b1;
        end
`ifdef SPI_FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (i_rx_data == csum) begin
            state_n = ST_STOP;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end
        end
`endif
        ST_STOP: begin
          state_n = ST_IDLE;
          if (i_rx_data == EOF) swap_n = 1'b1;
          else err_n = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (tmo_tc) begin
      state_n = ST_IDLE;
      err_n   = (state != ST_SYNC);
    end
  end

  always_ff @(posedge i_clk50m) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_swap      <= 1'b0;
      o_start     <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_count <= '0;
      dly_cnt     <= '0;
`ifdef SPI_FRAME_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      o_wr_en     <= wr_n;
      o_swap      <= swap_n;
      o_frame_err <= err_n;
`ifdef SPI_FRAME_CHECKSUM_EN
      csum        <= csum_n;
`endif
      if (wr_n) begin
        o_wr_addr <= idx;
        o_wr_data <= i_rx_data;
      end
      if (err_n && o_err_count != 8'hFF) o_err_count <= o_err_count + 1'b1;
      // A new swap reloads the delay, so overlapping swaps yield a single start.
      if (swap_n) dly_cnt <= DLY_W'(START_DELAY);
      else if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
      o_start <= (dly_cnt == DLY_W'(1)) && !swap_n;
    end
  end

  assign o_state = state;

endmodule

// File: doc/spi_frame_parser.md
# spi_frame_parser

Byte-level protocol parser between the SPI byte receiver and the LED double buffer. It consumes the received byte stream, detects the start sequence 0x55 0x5B, and writes LEDS*3 colour bytes into the back buffer. It validates the stop byte 0xAA, then issues the buffer swap followed by a delayed NeoPixel start pulse. Malformed, aborted or stalled frames are discarded and counted; a discarded frame never produces a swap.

## Interface
- LEDS, 30, number of LEDs; frame payload is LEDS*3 bytes
- ADDR_WIDTH, $clog2(LEDS*3), buffer write address width
- TIMEOUT_CYCLES, 500000, inter-byte timeout in clocks (10 ms at 50 MHz)
- START_DELAY, 2, clocks from o_swap to o_start

- i_clk50m  in  1  system clock, 50 MHz
- i_rst_n  in  1  reset: synchronous, active-low
- i_rx_data  in  8  received byte, valid while i_data_valid is high
- i_data_valid  in  1  single-cycle strobe per received byte
- i_cs  in  1  raw SPI chip select, active-low, asynchronous; synchronised internally with 2 FFs
- o_wr_en  out  1  back-buffer write strobe
- o_wr_addr  out  ADDR_WIDTH  write address, 0..LEDS*3-1
- o_wr_data  out  8  write data
- o_swap  out  1  single-cycle buffer-swap pulse
- o_start  out  1  single-cycle driver-start pulse
- o_frame_err  out  1  single-cycle pulse per discarded frame
- o_err_count  out  8  saturating count of discarded frames
- o_state  out  3  current state encoding, for the debug LEDs

## Operation
- States: IDLE=0, SYNC=1, DATA=2, CSUM=3 (macro only), STOP=4.
- IDLE: a valid byte of 0x55 moves to SYNC. All other bytes are ignored.
- SYNC:
  - valid 0x5B: go to DATA, clear index and checksum.
  - valid 0x55: stay in SYNC.
  - any other valid byte: go to IDLE. No error is raised.
- DATA: each valid byte is written to address index.
  - If index==LEDS*3-1, go to CSUM (macro) or STOP.
  - Otherwise index increments.
  - index never exceeds LEDS*3-1; there is no wrap.
- STOP:
  - valid 0xAA: pulse o_swap, go to IDLE.
  - any other valid byte: frame error, go to IDLE.
- Abort: a synchronised i_cs rising edge (deassert) in DATA, CSUM or STOP raises a frame error and returns to IDLE. If the abort and i_data_valid arrive in the same cycle, the abort wins and the byte is dropped.
- Timeout: a counter clears on every i_data_valid and on entry to SYNC. While not in IDLE, reaching TIMEOUT_CYCLES-1 raises a frame error and returns to IDLE. In SYNC this return is silent (no error).
- o_err_count increments on every o_frame_err and saturates at 255.
- Bytes already written by a discarded frame remain in the back buffer. They are harmless because no swap is issued.

## Timing
- Reset values: all outputs 0, state IDLE, index 0, timeout counter 0, start-delay counter idle.
- o_wr_en/o_wr_addr/o_wr_data are registered and asserted exactly one cycle after the DATA-state i_data_valid cycle, for one cycle.
- o_swap is asserted one cycle after the stop-byte strobe.
- o_start is asserted START_DELAY cycles after o_swap, for one cycle. A new o_swap during a pending delay restarts the delay, so only one o_start is issued.
- o_frame_err is asserted one cycle after the error condition, coincident with o_state==IDLE.
- Back-to-back strobes on consecutive cycles must be accepted with no byte loss.
- Reset asserted mid-frame returns to IDLE next clock. The pending o_start is cancelled and o_err_count is cleared.

## Configuration
- SPI_FRAME_CHECKSUM_EN defined:
  - A running XOR of all payload bytes is kept.
  - After the last data byte the state is CSUM. The next valid byte must equal the XOR; a match goes to STOP, a mismatch raises a frame error and returns to IDLE.
  - Frames are start+LEDS*3+1+stop bytes.
- SPI_FRAME_CHECKSUM_EN undefined: the CSUM state and the XOR register are absent, and the last data byte goes directly to STOP.

## Structure
- Shared package spi_led_pkg holds:
  - the state enum typedef
  - the constants SOF0=8'h55, SOF1=8'h5B, EOF=8'hAA
- Sub-module frame_timeout_counter: a load/clear counter with a terminal-count pulse, parameterised by TIMEOUT_CYCLES.

## Test plan
Bench uses LEDS=2 (6 payload bytes).
- Send 55 5B 01 02 03 04 05 06 AA. Expect 6 writes at addr 0..5 with data 01..06, then one o_swap, then o_start 2 cycles later, and o_err_count=0.
- Send 55 55 5B, then payload, then AA. Expect the frame accepted identically (repeated SOF0 tolerated).
- Send 55 5B, 6 bytes, then 0xAB. Expect no o_swap, one o_frame_err, o_err_count=1.
- Deassert i_cs after 3 payload bytes. Expect writes at addr 0..2 only, o_frame_err, state IDLE. A following good frame is accepted.
- Send 55 5B 01, then stall for TIMEOUT_CYCLES (bench override 100). Expect o_frame_err at cycle 100 with no swap.
- With SPI_FRAME_CHECKSUM_EN, send 01..06, then checksum 07, then AA. Expect a swap (01^02^03^04^05^06=07). A checksum byte of 00 must produce a frame error instead.
